// File: rtl/sisc_mux_pkg.sv
// Shared definitions for the SISC arbitrating output mux: mode encodings and
// the modulo-N increment used by the round-robin search.
package sisc_mux_pkg;

  localparam logic MODE_EXPLICIT = 1'b0;
  localparam logic MODE_RR       = 1'b1;

  // Compare-and-reset wrap so non-power-of-2 channel counts stay in range.
  function automatic logic [31:0] modInc(input logic [31:0] idx, input logic [31:0] n);
    logic [31:0] nxt;
    nxt = idx + 32'd1;
    return (nxt >= n) ? 32'd0 : nxt;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requesting channel after 'last', searching
// upward with wrap at NUM_IN.
module rr_pick
  import sisc_mux_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  last,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              gnt_vld
);

  logic [31:0] w_idx;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    w_idx   = 32'(last);
    for (int k = 0; k < NUM_IN; k++) begin
      w_idx = modInc(w_idx, 32'(NUM_IN));
      if (!gnt_vld && req[w_idx[SEL_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = w_idx[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mux_arb_reg.sv
// NUM_IN-way channel mux with explicit or round-robin selection, feeding a
// one-entry registered output stage behind a valid/ready handshake.
module mux_arb_reg
  import sisc_mux_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0]       r_outData;
  logic [SEL_W-1:0]       r_outSrc;
  logic                   r_outValid;
  logic [SEL_W-1:0]       r_last;

  logic [(2**SEL_W)-1:0]  w_validExt;
  logic                   w_selVld;
  logic [SEL_W-1:0]       w_rrIdx;
  logic                   w_rrVld;
  logic [SEL_W-1:0]       w_gntIdx;
  logic                   w_gntVld;
  logic                   w_canLoad;
  logic                   w_load;
  logic [WIDTH-1:0]       w_gntData;

  rr_pick #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_rr_pick (
    .req     (in_valid),
    .last    (r_last),
    .gnt_idx (w_rrIdx),
    .gnt_vld (w_rrVld)
  );

  // Padding the valid vector lets an out-of-range sel read a harmless zero.
  always_comb begin
    w_validExt               = '0;
    w_validExt[NUM_IN-1:0]   = in_valid;
    w_selVld                 = (32'(sel) < 32'(NUM_IN)) && w_validExt[sel];
  end

  always_comb begin
    w_gntIdx  = (mode == MODE_RR) ? w_rrIdx : sel;
    w_gntVld  = (mode == MODE_RR) ? w_rrVld : w_selVld;
    w_canLoad = !r_outValid || out_ready;
    w_load    = w_gntVld && w_canLoad && !rst;
  end

  always_comb begin
    in_ready  = '0;
    w_gntData = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (w_gntIdx == SEL_W'(i)) begin
        in_ready[i] = w_load;
        w_gntData   = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // A load can coincide with a drain, so the stage never inserts a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outSrc   <= '0;
      r_last     <= SEL_W'(NUM_IN - 1);
    end else if (w_load) begin
      r_outValid <= 1'b1;
      r_outData  <= w_gntData;
      r_outSrc   <= w_gntIdx;
      r_last     <= w_gntIdx;
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign out_data  = r_outData;
  assign out_src   = r_outSrc;
  assign out_valid = r_outValid;

endmodule

// File: tb/tb_mux_arb_reg.sv
// Bench for mux_arb_reg: a 4-channel and a 3-channel instance share stimulus
// and are compared each cycle against a behavioural reference.
module tb_mux_arb_reg;

  logic         clk = 1'b0;
  logic         rst;
  logic         mode;
  logic [1:0]   sel;
  logic [127:0] inData;
  logic [3:0]   inValid;
  logic         outReady;

  logic [3:0]   readyA;
  logic [31:0]  dataA;
  logic [1:0]   srcA;
  logic         validA;
  logic [2:0]   readyB;
  logic [31:0]  dataB;
  logic [1:0]   srcB;
  logic         validB;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    bit          outValid;
    logic [31:0] outData;
    int          outSrc;
    int          last;
  } refState_t;

  refState_t refA;
  refState_t refB;

  always #5 clk = ~clk;

  mux_arb_reg #(.WIDTH(32), .NUM_IN(4)) dutA (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_data(inData), .in_valid(inValid), .in_ready(readyA),
    .out_data(dataA), .out_src(srcA), .out_valid(validA), .out_ready(outReady)
  );

  mux_arb_reg #(.WIDTH(32), .NUM_IN(3)) dutB (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_data(inData[95:0]), .in_valid(inValid[2:0]), .in_ready(readyB),
    .out_data(dataB), .out_src(srcB), .out_valid(validB), .out_ready(outReady)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Granted channel or -1; explicit uses sel directly, RR scans after last.
  function automatic int refGrant(int n, bit m, int s, logic [3:0] v, int last);
    if (!m) return (s < n && v[s]) ? s : -1;
    for (int k = 1; k <= n; k++) begin
      int c;
      c = (last + k) % n;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] refReady(refState_t st, int n, bit r, bit m, int s, logic [3:0] v, bit oRdy);
    int g;
    g = refGrant(n, m, s, v, st.last);
    if (r || g < 0 || !(!st.outValid || oRdy)) return 4'b0;
    return 4'(1 << g);
  endfunction

  function automatic refState_t refNext(refState_t st, int n, bit r, bit m, int s, logic [3:0] v,
                                        logic [127:0] d, bit oRdy);
    refState_t nx;
    int g;
    nx = st;
    if (r) begin
      nx.outValid = 1'b0;
      nx.outData  = '0;
      nx.outSrc   = 0;
      nx.last     = n - 1;
      return nx;
    end
    g = refGrant(n, m, s, v, st.last);
    if (g >= 0 && (!st.outValid || oRdy)) begin
      nx.outValid = 1'b1;
      nx.outData  = d[g*32 +: 32];
      nx.outSrc   = g;
      nx.last     = g;
    end else if (oRdy) begin
      nx.outValid = 1'b0;
    end
    return nx;
  endfunction

  // One clock: drive, check combinational ready, advance, check registers.
  task automatic applyStimulus(input bit r, input bit m, input logic [1:0] s, input logic [3:0] v,
                               input logic [127:0] d, input bit oRdy);
    logic [3:0] maskB;
    @(negedge clk);
    rst = r; mode = m; sel = s; inValid = v; inData = d; outReady = oRdy;
    maskB = v & 4'b0111;
    #1;
    checkOutput("readyA", 64'(readyA), 64'(refReady(refA, 4, r, m, int'(s), v, oRdy)));
    checkOutput("readyB", 64'(readyB), 64'(refReady(refB, 3, r, m, int'(s), maskB, oRdy)));
    refA = refNext(refA, 4, r, m, int'(s), v, d, oRdy);
    refB = refNext(refB, 3, r, m, int'(s), maskB, d, oRdy);
    @(posedge clk);
    #1;
    checkOutput("validA", 64'(validA), 64'(refA.outValid));
    checkOutput("dataA",  64'(dataA),  64'(refA.outData));
    checkOutput("srcA",   64'(srcA),   64'(refA.outSrc));
    checkOutput("validB", 64'(validB), 64'(refB.outValid));
    checkOutput("dataB",  64'(dataB),  64'(refB.outData));
    checkOutput("srcB",   64'(srcB),   64'(refB.outSrc));
  endtask

  function automatic logic [127:0] patternData(int seed);
    logic [127:0] d;
    for (int i = 0; i < 4; i++) d[i*32 +: 32] = 32'(seed * 16 + i) ^ 32'hA5A50000;
    return d;
  endfunction

  initial begin
    logic [127:0] d;
    int srcSeq[$];
    refA = '{outValid: 1'b0, outData: '0, outSrc: 0, last: 3};
    refB = '{outValid: 1'b0, outData: '0, outSrc: 0, last: 2};
    rst = 1'b1; mode = 1'b0; sel = '0; inValid = '0; inData = '0; outReady = 1'b0;

    $display("[TB] reset with all channels valid");
    applyStimulus(1, 1, 0, 4'b1111, patternData(1), 1);
    applyStimulus(1, 1, 0, 4'b1111, patternData(2), 1);
    checkOutput("rst_readyA", 64'(readyA), 64'h0);
    applyStimulus(0, 1, 0, 4'b1111, patternData(3), 1);
    checkOutput("rst_firstSrc", 64'(srcA), 64'd0);

    $display("[TB] explicit select");
    d = '0;
    d[64 +: 32] = 32'hDEADBEEF;
    applyStimulus(0, 0, 2, 4'b0100, d, 1);
    checkOutput("exp_data", 64'(dataA), 64'hDEADBEEF);
    checkOutput("exp_src", 64'(srcA), 64'd2);
    applyStimulus(0, 0, 2, 4'b0001, d, 1);
    checkOutput("exp_drop", 64'(validA), 64'd0);
    applyStimulus(0, 0, 3, 4'b1111, patternData(4), 1);

    $display("[TB] round-robin rotation");
    applyStimulus(1, 1, 0, 4'b0000, '0, 1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1, 0, 4'b1111, patternData(10 + i), 1);
      srcSeq.push_back(int'(srcA));
      checkOutput("rr_noBubble", 64'(validA), 64'd1);
    end
    for (int i = 0; i < 6; i++) checkOutput("rr_seq", 64'(srcSeq[i]), 64'(i % 4));

    $display("[TB] sparse round-robin with wrap");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 0, 4'b0101, patternData(20 + i), 1);
      checkOutput("rr3_src", 64'(srcB), 64'((i % 2) * 2));
    end

    $display("[TB] backpressure");
    d = patternData(30);
    d[32 +: 32] = 32'h11111111;
    applyStimulus(0, 0, 1, 4'b0010, d, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 3, 4'b1000, patternData(31), 0);
      checkOutput("bp_hold", 64'(dataA), 64'h11111111);
    end
    applyStimulus(0, 0, 3, 4'b1000, patternData(31), 1);
    checkOutput("bp_src", 64'(srcA), 64'd3);

    $display("[TB] reset during stall");
    applyStimulus(0, 1, 0, 4'b0100, patternData(40), 0);
    applyStimulus(1, 1, 0, 4'b1111, patternData(41), 0);
    checkOutput("rst_stall", 64'(validA), 64'd0);
    applyStimulus(0, 1, 0, 4'b1111, patternData(42), 1);
    checkOutput("rst_stallSrc", 64'(srcA), 64'd0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      logic [127:0] rd;
      for (int w = 0; w < 4; w++) rd[w*32 +: 32] = $urandom;
      applyStimulus(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    4'($urandom), rd, ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mux_arb_reg.md
Name: mux_arb_reg

Overview:
- Parametrised successor to the 4:1 32-bit datapath mux.
- Selects one of NUM_IN WIDTH-bit channels and registers the result behind a valid/ready handshake.
- Two runtime modes: explicit select, as with the existing mux, or round-robin arbitration among the valid channels.
- Sits between operand/result producers and a shared consumer such as the register-file write port or the ALU operand bus in the SISC datapath.

Parameters:
- WIDTH, 32, data width per channel.
- NUM_IN, 4, number of input channels (2..16; need not be a power of 2).
- SEL_W, $clog2(NUM_IN), width of sel and out_src. Derived; do not override.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = explicit select, 1 = round-robin.
- sel  in  SEL_W  channel index used in explicit mode.
- in_data  in  NUM_IN*WIDTH  flattened channels; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  NUM_IN  per-channel valid.
- in_ready  out  NUM_IN  per-channel ready; at most one bit set.
- out_data  out  WIDTH  registered selected data.
- out_src  out  SEL_W  index of the channel that produced out_data.
- out_valid  out  1  out_data/out_src hold a transfer.
- out_ready  in  1  consumer accepts the output.

Behaviour:
- Reset (rst=1 at an edge):
  - out_valid=0, out_data=0, out_src=0.
  - RR pointer last=NUM_IN-1, so channel 0 has first priority.
  - in_ready is forced to all-zero while rst=1.
- can_load = !out_valid || out_ready. This is a one-entry output register with a combinational ready pass-through, giving full throughput.
- Grant, combinational:
  - Explicit mode: grant channel sel iff sel < NUM_IN and in_valid[sel]. If sel >= NUM_IN, no grant.
  - RR mode: grant the first i with in_valid[i], searching last+1, last+2, ... modulo NUM_IN. Wrap-around is by compare-and-reset, not bit truncation, so non-power-of-2 NUM_IN works.
  - No valid channel means no grant.
- in_ready[g] = grant_valid && can_load && !rst for the granted g; all other bits are 0.
- Transfer on channel g occurs when in_valid[g] && in_ready[g]. At the next edge:
  - out_data <= channel g, out_src <= g, out_valid <= 1.
  - last <= g. The pointer updates in both modes, so switching to RR continues fairly from the last winner.
- No transfer and out_ready=1: out_valid <= 0 at the next edge; out_data/out_src hold their values.
- No transfer and out_ready=0: all outputs hold. Stall; the registered data is stable.
- Simultaneous drain and load (out_valid=1, out_ready=1, grant present): the old word leaves and the new word loads in the same edge, with no bubble.
- Latency: 1 clock from the accepting edge to out_valid.
- Sources must not make in_valid depend on in_ready. in_ready depends combinationally on in_valid, sel, mode and out_ready.
- A mode or sel change takes effect combinationally in the same cycle. An already-registered word is unaffected.
- Reset mid-stall: the held word is discarded, out_valid=0 on the next edge, and the pointer returns to NUM_IN-1.
- No data is ever dropped or duplicated: each in_valid&in_ready pair yields exactly one out_valid&out_ready pair, in order.

Decomposition:
- Package sisc_mux_pkg:
  - MODE_EXPLICIT=1'b0 and MODE_RR=1'b1.
  - A function for the modulo-NUM_IN increment.
- One combinational sub-module, rr_pick (params NUM_IN, SEL_W):
  - Inputs: req[NUM_IN], last[SEL_W].
  - Outputs: gnt_idx[SEL_W], gnt_vld.
- mux_arb_reg holds the output register, the pointer, the explicit-select path and the ready logic.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0. After release in RR mode, the first grant is channel 0.
2. Explicit mode, sel=2, in_data ch2=0xDEADBEEF, in_valid=0100, out_ready=1 -> in_ready=0100. The next cycle gives out_valid=1, out_data=0xDEADBEEF, out_src=2. With sel=2 and in_valid=0001 -> no grant, and out_valid drops.
3. RR mode, in_valid=1111 continuous, out_ready=1 -> out_src sequence 0,1,2,3,0,1 with out_valid=1 every cycle and no bubbles.
4. RR mode, NUM_IN=3 build, in_valid=101 -> grants alternate 0,2,0,2. Verifies wrap at 2->0 with no index-3 grant.
5. Backpressure: load 0x11111111 from ch1, hold out_ready=0 for 3 cycles with ch3 valid -> out_data stays 0x11111111, in_ready=0000. When out_ready=1, ch3's word loads on that edge.
6. Reset mid-stall with out_valid=1 and out_ready=0 -> after the reset edge out_valid=0, and the next RR grant is channel 0.
